// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 types, constants and state encodings for the FPU datapath
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          FP_BIAS    = 127;
    localparam logic [31:0] FP_NAN     = 32'h7F800001;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;
    localparam logic [31:0] FP_ZERO    = 32'h00000000;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} fdiv_state_t;

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_t;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, FP_POS_INF[30:0]};
    endfunction

endpackage

// File: rtl/fpu_classify.sv
// rtl/fpu_classify.sv - combinational FP32 operand classifier; subnormals are reported as zero
module fpu_classify
    import fpu_pkg::*;
(
    input  fp32_t     value,
    output fp_class_t cls
);

    always_comb begin
        cls = CLS_NORM;
        if (value.exp == 8'hFF) begin
            cls = (value.frac != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (value.exp == 8'h00) begin
            cls = CLS_ZERO;
        end
    end

endmodule

// File: rtl/fpu_divider.sv
// rtl/fpu_divider.sv - iterative FP32 divider; FPU_DIV_ROUND_NEAREST_EN enables round-to-nearest-even
module fpu_divider
    import fpu_pkg::*;
#(
    parameter int          QBITS     = 26,
    parameter logic [31:0] NAN_VALUE = FP_NAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    fdiv_state_t        state, state_nxt;
    fp32_t              fa, fb;
    fp_class_t          cls_a, cls_b;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mb_q;
    logic [24:0]        rem_q;
    logic [QBITS-1:0]   quo_q;
    logic [4:0]         cnt_q;
    logic               special;
    logic [31:0]        special_val;
    logic               rem_ge;
    logic [24:0]        rem_sub;
    logic signed [9:0]  exp_n, exp_f;
    logic [22:0]        frac_t, frac_f;
    logic [31:0]        norm_val;
`ifdef FPU_DIV_ROUND_NEAREST_EN
    logic [QBITS-1:0]   quo_n;
    logic               guard, sticky;
    logic [23:0]        frac_r;
`endif

    assign fa = a;
    assign fb = b;

    fpu_classify u_cls_a (.value(fa), .cls(cls_a));
    fpu_classify u_cls_b (.value(fb), .cls(cls_b));

    always_comb begin
        special     = 1'b1;
        special_val = FP_ZERO;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            special_val = NAN_VALUE;
        end else if (cls_a == CLS_INF && cls_b == CLS_INF) begin
            special_val = NAN_VALUE;
        end else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) begin
            special_val = NAN_VALUE;
        end else if (cls_a == CLS_INF || cls_b == CLS_ZERO) begin
            special_val = fp_inf(fa.sign ^ fb.sign);
        end else if (cls_a == CLS_ZERO || cls_b == CLS_INF) begin
            special_val = FP_ZERO;
        end else begin
            special = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = special ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == 5'(QBITS - 1)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // remainder stays below 2*mb, so 25 bits never overflow
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    always_comb begin
        exp_n  = quo_q[QBITS-1] ? exp_q : exp_q - 10'sd1;
        frac_t = quo_q[QBITS-1] ? quo_q[QBITS-2 -: 23] : quo_q[QBITS-3 -: 23];
`ifdef FPU_DIV_ROUND_NEAREST_EN
        quo_n  = quo_q[QBITS-1] ? quo_q : {quo_q[QBITS-2:0], 1'b0};
        guard  = quo_n[QBITS-25];
        sticky = (|quo_n[QBITS-26:0]) | (|rem_q);
        frac_r = {1'b0, frac_t} + {23'd0, guard & (sticky | frac_t[0])};
        frac_f = frac_r[22:0];
        exp_f  = frac_r[23] ? exp_n + 10'sd1 : exp_n;
`else
        frac_f = frac_t;
        exp_f  = exp_n;
`endif
        if (exp_f >= 10'sd255)    norm_val = fp_inf(sign_q);
        else if (exp_f <= 10'sd0) norm_val = FP_ZERO;
        else                      norm_val = {sign_q, exp_f[7:0], frac_f};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= FP_ZERO;
            sign_q <= 1'b0;
            exp_q  <= 10'sd0;
            mb_q   <= 24'd0;
            rem_q  <= 25'd0;
            quo_q  <= '0;
            cnt_q  <= 5'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sign_q <= fa.sign ^ fb.sign;
                    exp_q  <= 10'({2'b00, fa.exp}) - 10'({2'b00, fb.exp}) + 10'(FP_BIAS);
                    mb_q   <= {1'b1, fb.frac};
                    rem_q  <= {2'b01, fa.frac};
                    quo_q  <= '0;
                    cnt_q  <= 5'd0;
                    if (special) result <= special_val;
                end
                DIVIDE: begin
                    rem_q <= {rem_sub[23:0], 1'b0};
                    quo_q <= {quo_q[QBITS-2:0], rem_ge};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM:    result <= norm_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_divider.sv
// tb/tb_fpu_divider.sv - directed self-checking bench for fpu_divider
module tb_fpu_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic [31:0] result;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    fpu_divider dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] expv, input int exp_lat);
        int lat;
        logic busy_ok;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~av; b = ~bv;
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 64) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, expv);
        check({tag, "_busy"}, 32'({busy, busy_ok}), 32'b11);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'({busy, done}), 32'b00);
        check({tag, "_hold"}, result, expv);
    endtask

    initial begin
        int  seen;
        logic [31:0] first_res;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("six_by_two", 32'h40C00000, 32'h40000000, 32'h40400000, 28);
`ifdef FPU_DIV_ROUND_NEAREST_EN
        run_div("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
`else
        run_div("one_by_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 28);
`endif
        run_div("neg_by_zero", 32'hBF800000, 32'h00000000, 32'hFF800000, 1);
        run_div("zero_by_zero", 32'h00000000, 32'h00000000, 32'h7F800001, 1);
        run_div("inf_by_inf", 32'h7F800000, 32'h7F800000, 32'h7F800001, 1);
        run_div("x_by_ninf", 32'h40000000, 32'hFF800000, 32'h00000000, 1);
        run_div("nan_by_x", 32'h7FC00000, 32'h40000000, 32'h7F800001, 1);
        run_div("overflow", 32'h7F000000, 32'h3F000000, 32'h7F800000, 28);
        run_div("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 28);
        run_div("neg_7p5", 32'hC0F00000, 32'h40200000, 32'hC0400000, 28);

        // abort a divide with reset; previous result is nonzero
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
        run_div("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, 28);

        // start pulses mid-divide and in the done cycle are ignored
        @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'h3F800000; b = 32'h40400000;
        seen = 0;
        first_res = 32'hFFFFFFFF;
        for (int k = 1; k <= 45; k++) begin
            if (done === 1'b1) begin
                if (seen == 0) begin
                    first_res = result;
                    check("ignore_lat", 32'(k), 32'd28);
                end
                seen++;
            end
            start = (k == 5 || k == 28);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("ignore_done_count", 32'(seen), 32'd1);
        check("ignore_result", first_res, 32'h40400000);
        check("ignore_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
